// File: rtl/button_event_scheduler.sv
// Debounced button front end: periodic sample strobe, per-channel debounce, rising-edge
// capture into pending flags, and a round-robin valid/ready event port.
module button_event_scheduler #(
    parameter int CH_W     = 2,
    parameter int PRESCALE = 1000,
    parameter int STABLE   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [(2**CH_W)-1:0]   level,
    output logic                   event_valid,
    output logic [CH_W-1:0]        event_ch,
    input  logic                   event_ready,
    output logic                   sample_tick,
    output logic                   overflow,
    input  logic                   ovf_clear
);
    localparam int N_CH    = 2**CH_W;
    localparam int PRESC_W = $clog2(PRESCALE);
    localparam int CNT_W   = $clog2(STABLE) + 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(STABLE - 1);

    typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

    logic [PRESC_W-1:0]          presc_q, presc_d;
    logic [N_CH-1:0]             flt_q, flt_d;
    logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]             pending_q, pending_d;
    logic [CH_W-1:0]             rr_ptr_q, rr_ptr_d;
    state_t                      state_q, state_d;
    logic                        event_valid_q, event_valid_d;
    logic [CH_W-1:0]             event_ch_q, event_ch_d;
    logic                        overflow_q, overflow_d;

    logic                        tick;
    logic [N_CH-1:0]             rise;
    logic                        accept;
    logic [N_CH-1:0]             clear_mask;
    logic [CH_W-1:0]             grant;
    logic [CH_W-1:0]             scan_idx;

    always_comb begin
        tick    = enable && (presc_q == PRESC_MAX);
        presc_d = presc_q;
        if (enable) begin
            presc_d = tick ? '0 : presc_q + PRESC_W'(1);
        end
        flt_d = flt_q;
        cnt_d = cnt_q;
        if (tick) begin
            for (int i = 0; i < N_CH; i++) begin
                if (level[i] == flt_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    flt_d[i] = level[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        rise = flt_d & ~flt_q;
    end

    // Descending scan so the channel closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        grant    = rr_ptr_q;
        scan_idx = rr_ptr_q;
        for (int k = N_CH - 1; k >= 0; k--) begin
            scan_idx = rr_ptr_q + CH_W'(k);
            if (pending_q[scan_idx]) begin
                grant = scan_idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        event_valid_d = event_valid_q;
        event_ch_d    = event_ch_q;
        rr_ptr_d      = rr_ptr_q;
        accept        = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    event_ch_d    = grant;
                    event_valid_d = 1'b1;
                    state_d       = PRESENT;
                end
            end
            PRESENT: begin
                if (event_ready) begin
                    accept        = 1'b1;
                    rr_ptr_d      = event_ch_q + CH_W'(1);
                    event_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        clear_mask = '0;
        if (accept) begin
            clear_mask[event_ch_q] = 1'b1;
        end
        // A rise on the channel being accepted re-arms it instead of counting as overflow.
        pending_d  = (pending_q & ~clear_mask) | rise;
        overflow_d = (|(rise & pending_q & ~clear_mask)) | (overflow_q & ~ovf_clear);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q       <= '0;
            flt_q         <= '1;
            cnt_q         <= '0;
            pending_q     <= '0;
            rr_ptr_q      <= '0;
            state_q       <= IDLE;
            event_valid_q <= 1'b0;
            event_ch_q    <= '0;
            overflow_q    <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            flt_q         <= flt_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            rr_ptr_q      <= rr_ptr_d;
            state_q       <= state_d;
            event_valid_q <= event_valid_d;
            event_ch_q    <= event_ch_d;
            overflow_q    <= overflow_d;
        end
    end

    assign event_valid = event_valid_q;
    assign event_ch    = event_ch_q;
    assign sample_tick = tick;
    assign overflow    = overflow_q;
endmodule
